// File: rtl/fc_vector_loader_if.sv
// ---------------------------------------------------------------------------
// fc_vector_loader_if
// Purpose : bundles the element stream going into the FC vector loader and
//           the assembled-vector handshake coming out of it.
// Signals : s_valid/s_ready/s_data/s_last - element stream, one element/beat
//           m_valid/m_ready/x              - parallel vector handoff
//           len_err                        - frame-length mismatch pulse
//           frame_cnt                      - vectors handed off (wraps)
// Modports: slave  - the loader itself
//           master - upstream source / downstream consumer side
// ---------------------------------------------------------------------------
interface fc_vector_loader_if #(
  parameter int WIDTH = 8,
  parameter int IN    = 400
);
  logic                        s_valid;
  logic                        s_ready;
  logic [WIDTH-1:0]            s_data;
  logic                        s_last;
  logic                        m_valid;
  logic                        m_ready;
  logic [0:IN-1][WIDTH-1:0]    x;
  logic                        len_err;
  logic [15:0]                 frame_cnt;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, x, len_err, frame_cnt
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, x, len_err, frame_cnt
  );
endinterface

// File: rtl/fc_vector_loader.sv
// ---------------------------------------------------------------------------
// fc_vector_loader
// Purpose : streaming front-end for the fully-parallel FC layers. Collects
//           IN activations (one per beat) into a registered parallel vector
//           x[0:IN-1], presents it with a valid/ready handshake and holds it
//           stable until accepted. Frames whose length differs from IN are
//           flagged with a one-cycle len_err pulse.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - fc_vector_loader_if.slave (stream in, vector out,
//                   len_err, frame_cnt)
// Params  : WIDTH (activation bits), IN (elements per vector); must match
//           the interface instance.
// Config  : FC_LOADER_DBUF_EN - when defined, two ping-pong vector banks so
//           filling continues while the other bank is presented. Undefined
//           (default) gives a single bank.
// ---------------------------------------------------------------------------
module fc_vector_loader #(
  parameter int WIDTH = 8,
  parameter int IN    = 400
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fc_vector_loader_if.slave    bus
);

  localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

  typedef logic [0:IN-1][WIDTH-1:0] vec_t;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic             len_err_q, len_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic beat, handoff, frame_done, early_last;

`ifdef FC_LOADER_DBUF_EN
  vec_t [1:0] bank_q, bank_d;
  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
`else
  typedef enum logic {FILL, FULL} state_t;
  state_t state_q, state_d;
  vec_t   x_q, x_d;
`endif

  assign beat       = bus.s_valid && s_ready_q;
  assign handoff    = m_valid_q && bus.m_ready;
  assign frame_done = beat && (idx_q == LAST_IDX);
  assign early_last = beat && bus.s_last && (idx_q != LAST_IDX);

  always_comb begin
    idx_d       = idx_q;
    len_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;

    // A frame always ends at IN elements; s_last only disagrees with that.
    if (frame_done) begin
      idx_d     = '0;
      len_err_d = !bus.s_last;
    end else if (early_last) begin
      idx_d     = '0;
      len_err_d = 1'b1;
    end else if (beat) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (handoff) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

`ifdef FC_LOADER_DBUF_EN
    bank_d   = bank_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;

    // While s_ready is high the write bank is never the full one, and a
    // completing frame and a handoff always touch different banks.
    if (beat) begin
      bank_d[wr_sel_q][idx_q] = bus.s_data;
    end
    if (frame_done) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
    end
    if (handoff) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end

    m_valid_d = full_d[rd_sel_d];
    s_ready_d = !(&full_d);
`else
    state_d = state_q;
    x_d     = x_q;

    // Only reachable in FILL, so the held vector is never disturbed.
    if (beat) begin
      x_d[idx_q] = bus.s_data;
    end

    case (state_q)
      FILL:    if (frame_done) state_d = FULL;
      FULL:    if (handoff)    state_d = FILL;
      default: state_d = FILL;
    endcase

    s_ready_d = (state_d == FILL);
    m_valid_d = (state_d == FULL);
`endif
  end

  // Handshake outputs are registered from the next state so neither ready
  // nor valid has a combinational path from the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      len_err_q   <= 1'b0;
      frame_cnt_q <= '0;
`ifdef FC_LOADER_DBUF_EN
      bank_q      <= '0;
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
`else
      state_q     <= FILL;
      x_q         <= '0;
`endif
    end else begin
      idx_q       <= idx_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      len_err_q   <= len_err_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FC_LOADER_DBUF_EN
      bank_q      <= bank_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
`else
      state_q     <= state_d;
      x_q         <= x_d;
`endif
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.len_err   = len_err_q;
  assign bus.frame_cnt = frame_cnt_q;
`ifdef FC_LOADER_DBUF_EN
  assign bus.x         = bank_q[rd_sel_q];
`else
  assign bus.x         = x_q;
`endif

endmodule

// File: tb/tb_fc_vector_loader.sv
// ---------------------------------------------------------------------------
// tb_fc_vector_loader
// Purpose : randomized bench for fc_vector_loader. Stimulus feeds a frame
//           model (plain queues) that predicts delivered vectors and
//           len_err pulse cycles; a negedge monitor compares the DUT against
//           those predictions. Honours FC_LOADER_DBUF_EN (two banks).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fc_vector_loader;
  localparam int WIDTH = 8;
  localparam int IN    = 400;
`ifdef FC_LOADER_DBUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  typedef logic [0:IN-1][WIDTH-1:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fc_vector_loader_if #(.WIDTH(WIDTH), .IN(IN)) bus ();

  fc_vector_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          total_checks = 0;
  int          fail_count   = 0;
  int unsigned cyc          = 0;
  bit          aborted      = 1'b0;
  bit          mr_random    = 1'b0;

  vec_t             exp_q[$];
  int unsigned      lenerr_q[$];
  logic [WIDTH-1:0] cur_frame[$];
  logic [15:0]      exp_frames = 16'd0;
  vec_t             zero_vec   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkVec(input string name, input vec_t act, input vec_t exp);
    int first;
    total_checks++;
    if (act !== exp) begin
      first = 0;
      for (int k = IN - 1; k >= 0; k--) if (act[k] !== exp[k]) first = k;
      fail_count++;
      $display("[TB] FAIL %s: x[%0d] got %0h expected %0h (cycle %0d)",
               name, first, act[first], exp[first], cyc);
    end
  endtask

  // Frame model: a frame is whatever arrives until IN elements or s_last.
  task automatic modelBeat(input logic [WIDTH-1:0] data, input logic last, input int unsigned beat_cyc);
    vec_t v;
    cur_frame.push_back(data);
    if (cur_frame.size() == IN) begin
      for (int k = 0; k < IN; k++) v[k] = cur_frame[k];
      exp_q.push_back(v);
      if (!last) lenerr_q.push_back(beat_cyc + 1);
      cur_frame.delete();
    end else if (last) begin
      lenerr_q.push_back(beat_cyc + 1);
      cur_frame.delete();
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last);
    int          waited;
    int unsigned beat_cyc;
    bit          accepted;
    waited   = 0;
    beat_cyc = 0;
    accepted = 1'b0;
    if (!aborted) begin
      bus.s_valid = 1'b1;
      bus.s_data  = data;
      bus.s_last  = last;
      while (!accepted && !aborted) begin
        @(negedge clk);
        if (bus.s_ready) begin
          beat_cyc = cyc;
          @(posedge clk);
          #1;
          accepted = 1'b1;
        end else begin
          waited++;
          if (waited > 3000) begin
            total_checks++;
            fail_count++;
            $display("[TB] FAIL s_ready_timeout: s_ready stayed 0 for %0d cycles, required 1", waited);
            aborted = 1'b1;
          end
        end
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      if (accepted) modelBeat(data, last, beat_cyc);
    end
  endtask

  task automatic sendFrame(input int n, input int last_at, input bit ramp, input int gap_max);
    logic [WIDTH-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = ramp ? WIDTH'(k % 256) : WIDTH'($urandom);
      applyStimulus(d, k == last_at);
      if (gap_max > 0) waitCycles(int'($urandom_range(gap_max, 0)));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    mr_random   = 1'b0;
    bus.m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total_checks++;
      fail_count++;
      $display("[TB] FAIL drain_timeout: %0d vectors outstanding, required 0", exp_q.size());
      aborted = 1'b1;
    end
    waitCycles(2);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_s_ready"},   32'(bus.s_ready),   32'd1);
    checkOutput({tag, "_m_valid"},   32'(bus.m_valid),   32'd0);
    checkOutput({tag, "_len_err"},   32'(bus.len_err),   32'd0);
    checkOutput({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
    checkVec({tag, "_x"}, bus.x, zero_vec);
  endtask

  // Randomised consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mr_random) bus.m_ready = 1'($urandom_range(1, 0));
    end
  end

  // Monitor: compares against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("m_valid", 32'(bus.m_valid), 32'(exp_q.size() > 0));
      checkOutput("s_ready", 32'(bus.s_ready), 32'(exp_q.size() < NBANK));
      if (bus.len_err) begin
        if (lenerr_q.size() == 0) checkOutput("len_err_spurious", 32'(bus.len_err), 32'd0);
        else                      checkOutput("len_err_cycle", cyc, lenerr_q.pop_front());
      end else if (lenerr_q.size() > 0 && lenerr_q[0] <= cyc) begin
        void'(lenerr_q.pop_front());
        checkOutput("len_err_missing", 32'(bus.len_err), 32'd1);
      end
      if (bus.m_valid && exp_q.size() > 0) begin
        checkVec("x", bus.x, exp_q[0]);
        checkOutput("frame_cnt", 32'(bus.frame_cnt), 32'(exp_frames));
        if (bus.m_ready) begin
          void'(exp_q.pop_front());
          exp_frames++;
        end
      end
    end
  end

  initial begin
    int n;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    rst_n = 1'b1;
    waitCycles(1);

    $display("[TB] ramp frame, m_ready high");
    sendFrame(IN, IN - 1, 1'b1, 0);
    drain();
    checkOutput("frame_cnt_first", 32'(bus.frame_cnt), 32'd1);

    $display("[TB] held vector with m_ready low");
    bus.m_ready = 1'b0;
    sendFrame(IN, IN - 1, 1'b0, 0);
    n = 0;
    while (!bus.m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hold_m_valid", 32'(bus.m_valid), 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    sendFrame(IN, IN - 1, 1'b0, 1);
    drain();

    $display("[TB] early s_last then full frame");
    sendFrame(6, 5, 1'b0, 0);
    waitCycles(3);
    sendFrame(IN, IN - 1, 1'b0, 0);
    drain();

    $display("[TB] frame without s_last");
    sendFrame(IN, -1, 1'b0, 0);
    drain();

    $display("[TB] random back-pressure frames");
    mr_random = 1'b1;
    for (int f = 0; f < 3; f++) sendFrame(IN, IN - 1, 1'b0, (NBANK == 2) ? 0 : 2);
    drain();

    $display("[TB] reset mid-frame");
    sendFrame(200, -1, 1'b0, 0);
    rst_n = 1'b0;
    cur_frame.delete();
    exp_q.delete();
    lenerr_q.delete();
    exp_frames = 16'd0;
    #1;
    checkReset("midreset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitCycles(1);
    sendFrame(IN, IN - 1, 1'b0, 0);
    drain();
    checkOutput("frame_cnt_final", 32'(bus.frame_cnt), 32'd1);
    checkOutput("len_err_pending", lenerr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
    $finish;
  end

endmodule
